// File: rtl/nibble_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_add_seq : serial adder, one 4-bit digit per cycle, valid/ready IO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module fullAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [IDXW+1:0] digit_lsb;
  logic            last_digit;
  logic [3:0]      fa_sum;
  logic            fa_cout;

  assign digit_lsb  = {idx_q, 2'b00};
  assign last_digit = (idx_q == IDXW'(NIBBLES - 1));

  // The only datapath: every digit of every operation goes through this adder.
  fullAdder u_fa (
    .a    (a_q[digit_lsb +: 4]),
    .b    (b_q[digit_lsb +: 4]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[digit_lsb +: 4] = fa_sum;
        carry_d               = fa_cout;
        idx_d                 = idx_q + IDXW'(1);
        if (last_digit) begin
          // The top digit's sum bit is the sign of the finished result.
          cout_d  = fa_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (fa_sum[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_add_seq : scoreboard bench for the serial nibble adder         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_nibble_add_seq;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           rise;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   ready_mode = 1;   // 0: hold low, 1: always high, 2: random
  int   hs_cyc     = 0;
  int   acc_cyc    = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer addition and signed range test.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    exp_t e;
    int   u;
    int   s;
    u      = int'(ta) + int'(tb_) + int'(tc);
    s      = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
    e.sum  = u[W-1:0];
    e.cout = u[W];
    e.ovf  = (s > 32767) || (s < -32768);
    e.rise = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    exp_t e;
    int   n;
    n        = 0;
    a        = ta;
    b        = tb_;
    cin      = tc;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept a=%0h b=%0h", ta, tb_);
      in_valid = 1'b0;
      return;
    end
    e       = model(ta, tb_, tc);
    acc_cyc = cyc + 1;
    e.rise  = acc_cyc + NIBBLES;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every DONE cycle against the head of the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=sum %0h required=no_result", sum);
        end else begin
          if (!prev_valid) chk("latency", 32'(cyc), 32'(sb[0].rise));
          chk("sum", 32'(sum), 32'(sb[0].sum));
          chk("cout", 32'(cout), 32'(sb[0].cout));
          chk("ovf", 32'(ovf), 32'(sb[0].ovf));
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            hs_cyc = cyc + 1;
            void'(sb.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(16'h1234, 16'h4321, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h0000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    drain();

    // Back-pressure in DONE while new operands wait on the input.
    ready_mode = 0;
    send(16'h0F0F, 16'h1010, 1'b1);
    fork
      send(16'hABCD, 16'h1111, 1'b0);
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (5) begin
          @(negedge clk);
          #2;
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        ready_mode = 1;
      end
    join
    chk("accept_after_release", 32'(acc_cyc), 32'(hs_cyc + 1));
    drain();

    // Reset in the middle of ADD, with digit index 2.
    send(16'h1234, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    send(16'h00FF, 16'h0F01, 1'b0);
    drain();

    ready_mode = 2;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
